// File: rtl/key_evt_pkg.sv
// Shared types for the key event scheduler.
//   key_state_t : per-key FSM encoding
//   EVT_PRESS / EVT_REPEAT : values carried on event_repeat
package key_evt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    PRESS = 2'b10,
    HOLD  = 2'b11
  } key_state_t;

  localparam logic EVT_PRESS  = 1'b0;
  localparam logic EVT_REPEAT = 1'b1;

endpackage

// File: rtl/key_hold_tracker.sv
// One key's press / auto-repeat generator.
//   clk, reset : clock, async active-low reset
//   level      : synchronous key level, 1 = pressed
//   req        : combinational request, asserted on the edge where the event is due
//   rep        : kind of the request (EVT_PRESS / EVT_REPEAT), valid with req
// After reset the key sits in IDLE until it is seen low, so a level held
// through reset release never produces a press.
module key_hold_tracker
  import key_evt_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic req,
  output logic rep
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    req = 1'b0;
    rep = EVT_PRESS;
    case (state)
      ARMED: req = level;
      PRESS: if (level && cnt == HOLD_LAST) begin req = 1'b1; rep = EVT_REPEAT; end
      HOLD:  if (level && cnt == REP_LAST)  begin req = 1'b1; rep = EVT_REPEAT; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:  if (!level) state <= ARMED;
        ARMED: if (level) begin state <= PRESS; cnt <= '0; end
        PRESS: begin
          if (!level)                 state <= ARMED;
          else if (cnt == HOLD_LAST)  begin state <= HOLD; cnt <= '0; end
          else                        cnt <= cnt + 1'b1;
        end
        HOLD: begin
          if (!level)                 state <= ARMED;
          else if (cnt == REP_LAST)   cnt <= '0;
          else                        cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Serializes press / auto-repeat events from N_KEYS keys onto one
// valid/ready event stream through a round-robin arbiter.
//   clk, reset   : clock, async active-low reset
//   level        : key levels, synchronous to clk
//   ready        : consumer takes the event when event_valid & ready
//   event_valid  : event present on event_id / event_repeat
//   event_id     : key index of the event
//   event_repeat : 0 = press, 1 = auto-repeat
//   pending      : per-key pending flags
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int ID_W          = 2,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] level,
  input  logic              ready,
  output logic              event_valid,
  output logic [ID_W-1:0]   event_id,
  output logic              event_repeat,
  output logic [N_KEYS-1:0] pending
);

  logic [N_KEYS-1:0] req, rep, pend, prep, grant;
  logic [ID_W-1:0]   ptr, pick;
  logic              may_load, found;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_hold_tracker #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_trk (
      .clk  (clk),
      .reset(reset),
      .level(level[g]),
      .req  (req[g]),
      .rep  (rep[g])
    );
  end

  assign may_load = !event_valid || ready;

  // First pending key at or after ptr, wrapping at N_KEYS (which need not be a power of 2).
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      j = int'(ptr) + k;
      if (j >= N_KEYS) j = j - N_KEYS;
      if (!found && pend[j]) begin
        found = 1'b1;
        pick  = ID_W'(j);
      end
    end
  end

  assign grant   = (may_load && found) ? (N_KEYS'(1) << pick) : '0;
  assign pending = pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend         <= '0;
      prep         <= '0;
      ptr          <= '0;
      event_valid  <= 1'b0;
      event_id     <= '0;
      event_repeat <= 1'b0;
    end else begin
      // A new request beats a same-edge grant; while pending, further
      // requests coalesce and keep the original kind.
      pend <= req | (pend & ~grant);
      for (int i = 0; i < N_KEYS; i++)
        if (req[i] && (!pend[i] || grant[i])) prep[i] <= rep[i];

      if (may_load) begin
        event_valid <= found;
        if (found) begin
          event_id     <= pick;
          event_repeat <= prep[pick];
          ptr          <= (pick == ID_W'(N_KEYS - 1)) ? '0 : pick + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;

  localparam int NK   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] level;
  logic          ready;
  logic          event_valid;
  logic [1:0]    event_id;
  logic          event_repeat;
  logic [NK-1:0] pending;

  int tests = 0;
  int fails = 0;

  key_event_scheduler #(
    .N_KEYS(NK), .ID_W(2), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .level(level), .ready(ready),
    .event_valid(event_valid), .event_id(event_id),
    .event_repeat(event_repeat), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: key activity as "cycles held since arming", events as
  // a pending set drained by a rotating scan.
  bit armed [NK];
  int run   [NK];
  bit mpend [NK];
  bit mrep  [NK];
  int mptr;
  bit ov;
  int oid;
  bit orep;

  // Accepted DUT events, indexed id*2 + repeat.
  int ecnt [NK*2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NK; i++) begin
      armed[i] = 0; run[i] = 0; mpend[i] = 0; mrep[i] = 0;
    end
    mptr = 0; ov = 0; oid = 0; orep = 0;
  endfunction

  function automatic void model_step(input logic [NK-1:0] lv, input logic rdy);
    int g;
    bit rq, rk;
    g = -1;
    if (!ov || rdy) begin
      for (int k = 0; k < NK; k++)
        if (g < 0 && mpend[(mptr + k) % NK]) g = (mptr + k) % NK;
      if (g >= 0) begin
        ov = 1; oid = g; orep = mrep[g]; mptr = (g + 1) % NK;
      end else ov = 0;
    end
    for (int i = 0; i < NK; i++) begin
      rq = 0; rk = 0;
      if (lv[i]) begin
        if (armed[i]) begin
          run[i]++;
          if (run[i] == 1) rq = 1;
          else if (run[i] - 1 >= HOLD && (run[i] - 1 - HOLD) % REP == 0) begin rq = 1; rk = 1; end
        end
      end else begin
        armed[i] = 1; run[i] = 0;
      end
      if (g == i) mpend[i] = 0;
      if (rq) begin
        if (!mpend[i]) mrep[i] = rk;
        mpend[i] = 1;
      end
    end
  endfunction

  function automatic void clr_cnt();
    for (int i = 0; i < NK*2; i++) ecnt[i] = 0;
  endfunction

  task automatic step();
    logic [NK-1:0] mp;
    if (event_valid && ready) ecnt[int'(event_id)*2 + int'(event_repeat)]++;
    @(posedge clk);
    model_step(level, ready);
    #1;
    for (int i = 0; i < NK; i++) mp[i] = mpend[i];
    chk("valid", {31'd0, event_valid}, {31'd0, ov});
    if (ov) begin
      chk("id", {30'd0, event_id}, oid);
      chk("repeat", {31'd0, event_repeat}, {31'd0, orep});
    end
    chk("pending", {28'd0, pending}, {28'd0, mp});
  endtask

  // Called just after an active edge; asserts reset between edges.
  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {31'd0, event_valid}, 0);
    chk("rst_id", {30'd0, event_id}, 0);
    chk("rst_repeat", {31'd0, event_repeat}, 0);
    chk("rst_pending", {28'd0, pending}, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; level = '0; ready = 1'b1;
    model_reset();
    clr_cnt();
    repeat (2) @(posedge clk);
    #1;
    chk("por_valid", {31'd0, event_valid}, 0);
    chk("por_pending", {28'd0, pending}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step();

    // 1: single-cycle press on key 1
    clr_cnt();
    level = 4'b0010; step();
    chk("t1_pend", {28'd0, pending}, 32'h2);
    level = '0; step();
    chk("t1_valid", {31'd0, event_valid}, 1);
    chk("t1_id", {30'd0, event_id}, 1);
    chk("t1_rep", {31'd0, event_repeat}, 0);
    step();
    chk("t1_drop", {31'd0, event_valid}, 0);
    repeat (3) step();
    chk("t1_count", ecnt[2], 1);

    // 2: key 2 held 20 cycles -> press + repeats after 8, 12, 16
    clr_cnt();
    level = 4'b0100;
    repeat (20) step();
    level = '0;
    repeat (6) step();
    chk("t2_press", ecnt[4], 1);
    chk("t2_repeats", ecnt[5], 3);

    // 3: all keys together from ptr 0
    do_reset();
    repeat (2) step();
    level = 4'b1111; step();
    level = '0;
    for (int k = 0; k < NK; k++) begin
      step();
      chk("t3_id", {30'd0, event_id}, k);
      chk("t3_rep", {31'd0, event_repeat}, 0);
    end
    step();
    chk("t3_idle", {31'd0, event_valid}, 0);

    // 4: stall with keys 0 and 3 pending; ptr is back at 0
    ready = 1'b0;
    level = 4'b1001; step();
    level = '0;
    repeat (7) begin
      step();
      chk("t4_hold_id", {30'd0, event_id}, 0);
    end
    ready = 1'b1; step();
    chk("t4_next", {30'd0, event_id}, 3);
    repeat (3) step();

    // 5: key 0 held through a 30-cycle stall -> repeats coalesce
    ready = 1'b0;
    level = 4'b0001;
    repeat (30) step();
    level = '0; ready = 1'b1;
    clr_cnt();
    repeat (5) step();
    chk("t5_press", ecnt[0], 1);
    chk("t5_repeat", ecnt[1], 1);

    // 6: reset mid-operation with key 1 held through release
    ready = 1'b0;
    level = 4'b0110; step();
    level = 4'b0010; step();
    chk("t6_pre_valid", {31'd0, event_valid}, 1);
    do_reset();
    ready = 1'b1;
    clr_cnt();
    repeat (15) step();
    chk("t6_no_evt", ecnt[2] + ecnt[3], 0);
    level = '0; step();
    level = 4'b0010; step();
    level = '0;
    repeat (4) step();
    chk("t6_after", ecnt[2], 1);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(7) == 0) level[i] = ~level[i];
      ready = ($urandom_range(3) != 0);
      if (n == 250) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
